// File: rtl/dpi_seq_pkg.sv
// Shared widths and FSM encoding for the DPI stream sequencer and its stream table.
package dpi_seq_pkg;

    localparam int unsigned STREAM_ID_W = 6;
    localparam int unsigned NUM_STREAMS = 64;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned GAP_CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GAP,
        STREAM,
        DRAIN,
        EOP
    } seq_state_e;

endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream seen bitmap and regex enable-mask table with combinational lookup.
module dpi_stream_table
    import dpi_seq_pkg::*;
#(
    parameter int unsigned NUM_REGEX = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we_i,
    input  logic [STREAM_ID_W-1:0] cfg_id_i,
    input  logic [NUM_REGEX-1:0]   cfg_mask_i,
    input  logic                   clr_i,
    input  logic [STREAM_ID_W-1:0] clr_id_i,
    input  logic                   set_i,
    input  logic [STREAM_ID_W-1:0] set_id_i,
    input  logic [STREAM_ID_W-1:0] rd_id_i,
    output logic [NUM_REGEX-1:0]   rd_mask_c,
    output logic                   rd_seen_c
);

    logic [NUM_STREAMS-1:0] seen_q, seen_d;
    logic [NUM_REGEX-1:0]   mask_q [NUM_STREAMS];

    // Clear is applied after set so a same-cycle clear of the committing stream wins.
    always_comb begin
        seen_d = seen_q;
        if (set_i) seen_d[set_id_i] = 1'b1;
        if (clr_i) seen_d[clr_id_i] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else begin
            seen_q <= seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                mask_q[i] <= '0;
            end
        end else if (cfg_we_i) begin
            mask_q[cfg_id_i] <= cfg_mask_i;
        end
    end

    // Reads see the pre-write contents when a write lands in the same cycle.
    assign rd_mask_c = mask_q[rd_id_i];
    assign rd_seen_c = seen_q[rd_id_i];

endmodule

// File: rtl/dpi_stream_sequencer.sv
// Drives the load/stream/eop sequence for the per-regex matcher wrappers.
// Define DPI_SEQ_STATS_EN to add saturating pkt_count / drop_count outputs.
module dpi_stream_sequencer
    import dpi_seq_pkg::*;
#(
    parameter int unsigned NUM_REGEX = 16,
    parameter int unsigned LOAD_GAP  = 1,
    parameter int unsigned EOP_GAP   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [STREAM_ID_W-1:0] in_stream_id,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_stream_id,
    input  logic [NUM_REGEX-1:0]   cfg_mask,
    input  logic                   clr_vld,
    input  logic [STREAM_ID_W-1:0] clr_stream_id,
    output logic                   load_state,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   new_stream_id,
    output logic [DATA_W-1:0]      char_in,
    output logic                   char_in_vld,
    output logic                   eop,
    output logic [NUM_REGEX-1:0]   enable
`ifdef DPI_SEQ_STATS_EN
    ,
    output logic [15:0]            pkt_count,
    output logic [15:0]            drop_count
`endif
);

    seq_state_e             state_q, state_d;
    logic [GAP_CNT_W-1:0]   gap_q, gap_d;
    logic                   rdy_c;
    logic                   start_c;
    logic                   accept_c;
    logic [NUM_REGEX-1:0]   tbl_mask_c;
    logic                   tbl_seen_c;

    logic [STREAM_ID_W-1:0] sid_q;
    logic [NUM_REGEX-1:0]   en_q;
    logic                   new_q;
    logic                   load_q;
    logic [DATA_W-1:0]      char_q;
    logic                   char_vld_q;
    logic                   eop_q;

    // Next-state: the SOP beat is only peeked in IDLE and consumed later in STREAM.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        rdy_c    = 1'b0;
        start_c  = 1'b0;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                rdy_c = in_vld && !in_sop;
                if (in_vld && in_sop) begin
                    start_c = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = GAP;
                gap_d   = GAP_CNT_W'(LOAD_GAP - 1);
            end
            GAP: begin
                if (gap_q == '0) state_d = STREAM;
                else             gap_d   = gap_q - GAP_CNT_W'(1);
            end
            STREAM: begin
                rdy_c    = 1'b1;
                accept_c = in_vld;
                if (in_vld && in_eop) begin
                    state_d = DRAIN;
                    gap_d   = GAP_CNT_W'(EOP_GAP - 1);
                end
            end
            DRAIN: begin
                if (gap_q == '0) state_d = EOP;
                else             gap_d   = gap_q - GAP_CNT_W'(1);
            end
            EOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = rst_n && rdy_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            sid_q      <= '0;
            en_q       <= '0;
            new_q      <= 1'b0;
            load_q     <= 1'b0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            load_q     <= start_c;
            char_vld_q <= accept_c;
            eop_q      <= (state_q == DRAIN) && (gap_q == '0);
            if (accept_c) char_q <= in_data;
            if (start_c) begin
                sid_q <= in_stream_id;
                en_q  <= tbl_mask_c;
                new_q <= !tbl_seen_c;
            end
        end
    end

    dpi_stream_table #(
        .NUM_REGEX (NUM_REGEX)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we_i   (cfg_we),
        .cfg_id_i   (cfg_stream_id),
        .cfg_mask_i (cfg_mask),
        .clr_i      (clr_vld),
        .clr_id_i   (clr_stream_id),
        .set_i      (state_q == EOP),
        .set_id_i   (sid_q),
        .rd_id_i    (in_stream_id),
        .rd_mask_c  (tbl_mask_c),
        .rd_seen_c  (tbl_seen_c)
    );

    assign load_state    = load_q;
    assign stream_id     = sid_q;
    assign new_stream_id = new_q;
    assign char_in       = char_q;
    assign char_in_vld   = char_vld_q;
    assign eop           = eop_q;
    assign enable        = en_q;

`ifdef DPI_SEQ_STATS_EN
    logic [15:0] pkt_q;
    logic [15:0] drop_q;
    logic        drop_c;

    assign drop_c = (state_q == IDLE) && in_vld && !in_sop;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            if ((state_q == EOP) && (pkt_q != 16'hFFFF)) pkt_q  <= pkt_q + 16'd1;
            if (drop_c && (drop_q != 16'hFFFF))          drop_q <= drop_q + 16'd1;
        end
    end

    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Randomized directed bench for dpi_stream_sequencer against a packet-level reference model.
module tb_dpi_stream_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_vld, in_sop, in_eop, cfg_we, clr_vld, sel2;
    logic [7:0]  in_data;
    logic [5:0]  in_stream_id, cfg_stream_id, clr_stream_id;
    logic [15:0] cfg_mask;

    logic        rdy1, load1, new1, chv1, eop1;
    logic [5:0]  sid1;
    logic [7:0]  ch1;
    logic [15:0] en1;
    logic        rdy2, load2, new2, chv2, eop2;
    logic [5:0]  sid2;
    logic [7:0]  ch2;
    logic [15:0] en2;
`ifdef DPI_SEQ_STATS_EN
    logic [15:0] pc1, dc1, pc2, dc2;
`endif

    dpi_stream_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld && !sel2), .in_ready(rdy1),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_stream_id(in_stream_id),
        .cfg_we(cfg_we), .cfg_stream_id(cfg_stream_id), .cfg_mask(cfg_mask),
        .clr_vld(clr_vld), .clr_stream_id(clr_stream_id),
        .load_state(load1), .stream_id(sid1), .new_stream_id(new1), .char_in(ch1),
        .char_in_vld(chv1), .eop(eop1), .enable(en1)
`ifdef DPI_SEQ_STATS_EN
        , .pkt_count(pc1), .drop_count(dc1)
`endif
    );

    dpi_stream_sequencer #(.NUM_REGEX(16), .LOAD_GAP(2), .EOP_GAP(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld && sel2), .in_ready(rdy2),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_stream_id(in_stream_id),
        .cfg_we(cfg_we), .cfg_stream_id(cfg_stream_id), .cfg_mask(cfg_mask),
        .clr_vld(clr_vld), .clr_stream_id(clr_stream_id),
        .load_state(load2), .stream_id(sid2), .new_stream_id(new2), .char_in(ch2),
        .char_in_vld(chv2), .eop(eop2), .enable(en2)
`ifdef DPI_SEQ_STATS_EN
        , .pkt_count(pc2), .drop_count(dc2)
`endif
    );

    logic        o_ready, o_load, o_new, o_chv, o_eop;
    logic [5:0]  o_sid;
    logic [7:0]  o_ch;
    logic [15:0] o_en;
    assign o_ready = sel2 ? rdy2  : rdy1;
    assign o_load  = sel2 ? load2 : load1;
    assign o_new   = sel2 ? new2  : new1;
    assign o_chv   = sel2 ? chv2  : chv1;
    assign o_eop   = sel2 ? eop2  : eop1;
    assign o_sid   = sel2 ? sid2  : sid1;
    assign o_ch    = sel2 ? ch2   : ch1;
    assign o_en    = sel2 ? en2   : en1;

    // Reference model: table contents, seen bitmaps and last char per instance.
    bit          m_seen [2][64];
    logic [15:0] m_table [64];
    logic [7:0]  m_last [2];
    int          m_pkts [2];
    int          m_drops;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_seen[0][i] = 1'b0;
            m_seen[1][i] = 1'b0;
            m_table[i]   = 16'h0;
        end
        m_last[0] = 8'h0; m_last[1] = 8'h0;
        m_pkts[0] = 0;    m_pkts[1] = 0;
        m_drops   = 0;
    endtask

    task automatic cfg_write(input int id, input logic [15:0] mask);
        cfg_we = 1'b1; cfg_stream_id = 6'(id); cfg_mask = mask;
        step();
        m_table[id] = mask;
        cfg_we = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({o_load, o_new, o_chv, o_eop}), 32'h0);
        chk({tag, "_sid"}, 32'(o_sid), 32'h0);
        chk({tag, "_ch"},  32'(o_ch),  32'h0);
        chk({tag, "_en"},  32'(o_en),  32'h0);
    endtask

    // Send one packet; timing follows load=t0, first char >= t0+lg+2, eop = last char + eg.
    // cfg_mode: 1 = write this stream mid-packet, 2 = write in the SOP cycle.
    // clr_mode: 1 = clear in the eop cycle, 2 = clear early in the packet.
    task automatic run_pkt(input int id, input int len, input bit u, input logic [7:0] b0,
                           input int cfg_mode, input logic [15:0] cfg_new,
                           input int clr_mode, input int abort_at);
        int lg, eg, nb, acc_t;
        bit acc_done, prev_acc, done, exp_rdy, exp_eop, exp_new;
        logic [15:0] exp_en;
        logic [7:0]  d [$];
        lg = u ? 2 : 1;
        eg = u ? 3 : 1;
        sel2 = u;
        d.push_back(b0);
        for (int k = 1; k < len; k++) d.push_back(8'($urandom));
        exp_new = !m_seen[u][id];
        exp_en  = m_table[id];
        in_vld = 1'b1; in_sop = 1'b1; in_eop = (len == 1);
        in_stream_id = 6'(id); in_data = d[0];
        if (cfg_mode == 2) begin
            cfg_we = 1'b1; cfg_stream_id = 6'(id); cfg_mask = cfg_new; m_table[id] = cfg_new;
        end
        #1 chk("sop_not_consumed", 32'(o_ready), 32'h0);
        step();
        nb = 0; acc_t = 0; acc_done = 1'b0; prev_acc = 1'b0; done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            chk("load_state", 32'(o_load), 32'(t == 0));
            chk("stream_id", 32'(o_sid), 32'(id));
            chk("enable", 32'(o_en), 32'(exp_en));
            if (t == 0) chk("new_stream_id", 32'(o_new), 32'(exp_new));
            chk("char_in_vld", 32'(o_chv), 32'(prev_acc));
            if (prev_acc) m_last[u] = d[nb-1];
            chk("char_in", 32'(o_ch), 32'(m_last[u]));
            exp_eop = acc_done && (t == acc_t + 1 + eg);
            chk("eop", 32'(o_eop), 32'(exp_eop));
            cfg_we = 1'b0; clr_vld = 1'b0;
            if (abort_at == t) begin
                rst_n = 1'b0; in_vld = 1'b0;
                return;
            end
            if (exp_eop) begin
                done = 1'b1;
                m_seen[u][id] = 1'b1;
                m_pkts[u]++;
                if (clr_mode == 1) begin
                    clr_vld = 1'b1; clr_stream_id = 6'(id);
                    m_seen[0][id] = 1'b0; m_seen[1][id] = 1'b0;
                end
            end
            if (t == 1 && cfg_mode == 1) begin
                cfg_we = 1'b1; cfg_stream_id = 6'(id); cfg_mask = cfg_new; m_table[id] = cfg_new;
            end
            if (t == 1 && clr_mode == 2) begin
                clr_vld = 1'b1; clr_stream_id = 6'(id);
                m_seen[0][id] = 1'b0; m_seen[1][id] = 1'b0;
            end
            if (t > 0) in_stream_id = 6'($urandom);
            if (prev_acc) begin
                if (nb < len) begin
                    in_data = d[nb];
                    in_sop  = 1'($urandom);
                    in_eop  = (nb == len - 1);
                    in_vld  = ($urandom_range(0, 3) != 0);
                end else begin
                    in_vld = 1'b0;
                end
            end else if (!in_vld && nb < len) begin
                in_vld = ($urandom_range(0, 3) != 0);
            end
            exp_rdy = (t >= lg + 1) && !acc_done;
            #1 chk("in_ready", 32'(o_ready), 32'(exp_rdy));
            prev_acc = in_vld && exp_rdy;
            if (prev_acc) begin
                nb++;
                if (nb == len) begin
                    acc_done = 1'b1;
                    acc_t = t;
                end
            end
            step();
        end
        if (!done) chk("pkt_timeout", 32'h0, 32'h1);
        in_vld = 1'b0; cfg_we = 1'b0; clr_vld = 1'b0;
        chk("post_eop_quiet", 32'({o_load, o_chv, o_eop}), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 8'h0;
        in_stream_id = 6'h0; cfg_we = 1'b0; cfg_stream_id = 6'h0; cfg_mask = 16'h0;
        clr_vld = 1'b0; clr_stream_id = 6'h0; sel2 = 1'b0;
        model_reset();
        step();
        step();
        #1 chk("reset_in_ready", 32'(o_ready), 32'h0);
        chk_zero_outputs("reset");
        rst_n = 1'b1; in_vld = 1'b0;
        step();

        cfg_write(5, 16'h00A1);
        cfg_write(7, 16'h1234);
        cfg_write(63, 16'hBEEF);
        cfg_write(9, 16'h0F0F);

        // First packet on stream 5, then a repeat on the now-seen stream.
        run_pkt(5, 4, 1'b0, 8'h10, 0, 16'h0, 0, -1);
        run_pkt(5, 5, 1'b0, 8'h20, 0, 16'h0, 0, -1);

        // Single-beat packet on the LOAD_GAP=2 / EOP_GAP=3 instance.
        run_pkt(63, 1, 1'b1, 8'h41, 0, 16'h0, 0, -1);

        // Non-SOP beats in IDLE are accepted and dropped.
        sel2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_sop = 1'b0; in_eop = 1'($urandom); in_data = 8'($urandom);
            #1 chk("drop_ready", 32'(o_ready), 32'h1);
            m_drops++;
            step();
            chk("drop_quiet", 32'({o_load, o_chv, o_eop}), 32'h0);
        end
        in_vld = 1'b0;
`ifdef DPI_SEQ_STATS_EN
        chk("drop_count", 32'(dc1), 32'(m_drops));
`endif

        // Mid-packet write to the active stream only shows up on the next packet.
        run_pkt(7, 4, 1'b0, 8'h30, 1, 16'h5A5A, 0, -1);
        run_pkt(7, 2, 1'b0, 8'h31, 0, 16'h0, 0, -1);

        // Clear coinciding with eop wins; an earlier clear is overwritten by eop.
        run_pkt(9, 3, 1'b0, 8'h40, 0, 16'h0, 1, -1);
        run_pkt(9, 2, 1'b0, 8'h41, 0, 16'h0, 2, -1);
        run_pkt(9, 2, 1'b0, 8'h42, 0, 16'h0, 0, -1);

        // Table write in the same cycle as the SOP lookup returns the old mask.
        cfg_write(3, 16'h1111);
        run_pkt(3, 2, 1'b0, 8'h50, 2, 16'h2222, 0, -1);
        run_pkt(3, 1, 1'b1, 8'h51, 0, 16'h0, 0, -1);

        for (int i = 0; i < 10; i++) begin
            run_pkt($urandom_range(16, 19), $urandom_range(1, 6), 1'($urandom), 8'($urandom),
                    $urandom_range(0, 2), 16'($urandom), $urandom_range(0, 2), -1);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
`ifdef DPI_SEQ_STATS_EN
        chk("pkt_count_dut1", 32'(pc1), 32'(m_pkts[0]));
        chk("pkt_count_dut2", 32'(pc2), 32'(m_pkts[1]));
`endif

        // Reset in the middle of a streaming packet.
        run_pkt(12, 6, 1'b0, 8'h60, 0, 16'h0, 0, 4);
        in_vld = 1'b1; in_sop = 1'b0;
        #1 chk("abort_in_ready", 32'(o_ready), 32'h0);
        step();
        chk_zero_outputs("abort");
        rst_n = 1'b1; in_vld = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_eop", 32'({o_load, o_chv, o_eop}), 32'h0);
        end
`ifdef DPI_SEQ_STATS_EN
        chk("abort_pkt_count", 32'(pc1), 32'h0);
`endif
        run_pkt(5, 3, 1'b0, 8'h70, 0, 16'h0, 0, -1);
        run_pkt(12, 2, 1'b1, 8'h71, 0, 16'h0, 0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
